// File: rtl/fmap_pkg.sv
// Shared feature-map storage definitions used by both the capture writer and the readback engine.
package fmap_pkg;

  localparam int PIXEL_W      = 16;
  localparam int BRAM_W       = 256;
  localparam int BRAM_ADDR_W  = 12;
  localparam int PIX_PER_WORD = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_PRESENT,
    ST_DONE
  } rb_state_e;

  function automatic int words_per_col(input int pix_h);
    return (pix_h * PIXEL_W + BRAM_W - 1) / BRAM_W;
  endfunction

endpackage

// File: rtl/fmap_readback_256_bram_rd_pipe.sv
// Delay line that carries {valid, word index} from a BRAM address cycle to the matching data cycle.
module bram_rd_pipe #(
  parameter int LATENCY = 1,
  parameter int IDX_W   = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [LATENCY-1:0] valid_q;
  logic [IDX_W-1:0]   idx_q [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) idx_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      idx_q[0]   <= idx_i;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign idx_o   = idx_q[LATENCY-1];

endmodule

// File: rtl/fmap_readback_256.sv
// Feature-map readback: fetches each stored column from BRAM and presents it as one valid/ready column beat.
module fmap_readback_256
  import fmap_pkg::*;
#(
  parameter int                     PIX_H      = 24,
  parameter int                     NUM_COLS   = 24,
  parameter logic [BRAM_ADDR_W-1:0] BASE_ADDR  = 12'h000,
  parameter int                     RD_LATENCY = 1
) (
  input  logic                   out_stream_aclk,
  input  logic                   periph_resetn,
  input  logic                   start,
  output logic [BRAM_ADDR_W-1:0] bram_addr_b,
  output logic                   bram_en_b,
  input  logic [BRAM_W-1:0]      bram_rddata_b,
  output logic                   col_valid,
  input  logic                   col_ready,
  output logic [PIXEL_W-1:0]     data_col [PIX_H-1:0],
  output logic                   col_last,
  output logic                   busy,
  output logic                   done
);

  localparam int WORDS_PER_COL = words_per_col(PIX_H);
  localparam int IDX_W = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  if (int'(BASE_ADDR) + NUM_COLS * WORDS_PER_COL > (1 << BRAM_ADDR_W)) begin : g_addr_range_chk
    $error("fmap_readback_256: feature map does not fit in the BRAM address space");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_latency_chk
    $error("fmap_readback_256: RD_LATENCY must be 1..3");
  end

  rb_state_e              state_q, state_d;
  logic [COL_W-1:0]       colCnt_q, colCnt_d;
  logic [IDX_W-1:0]       wordCnt_q, wordCnt_d;
  logic [BRAM_ADDR_W-1:0] nextAddr_q, nextAddr_d;
  logic [BRAM_ADDR_W-1:0] bramAddr_q, bramAddr_d;
  logic [BRAM_ADDR_W-1:0] issueAddr;
  logic [PIXEL_W-1:0]     dataCol_q [PIX_H-1:0];
  logic                   pipeValid;
  logic [IDX_W-1:0]       pipeIdx;
  logic                   colLastNow;

  // Padding bits above the last pixel are never stored; fold them away.
  logic unusedRdBits;
  assign unusedRdBits = ^bram_rddata_b;

  bram_rd_pipe #(
    .LATENCY(RD_LATENCY),
    .IDX_W  (IDX_W)
  ) u_rd_pipe (
    .clk_i  (out_stream_aclk),
    .rst_ni (periph_resetn),
    .valid_i(state_q == ST_ISSUE),
    .idx_i  (wordCnt_q),
    .valid_o(pipeValid),
    .idx_o  (pipeIdx)
  );

  assign colLastNow = (colCnt_q == COL_W'(NUM_COLS - 1));

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state_q    <= ST_IDLE;
      colCnt_q   <= '0;
      wordCnt_q  <= '0;
      nextAddr_q <= '0;
      bramAddr_q <= '0;
    end else begin
      state_q    <= state_d;
      colCnt_q   <= colCnt_d;
      wordCnt_q  <= wordCnt_d;
      nextAddr_q <= nextAddr_d;
      bramAddr_q <= bramAddr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    colCnt_d   = colCnt_q;
    wordCnt_d  = wordCnt_q;
    nextAddr_d = nextAddr_q;
    bramAddr_d = bramAddr_q;
    issueAddr  = nextAddr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ISSUE;
          colCnt_d  = '0;
          wordCnt_d = '0;
        end
      end
      ST_ISSUE: begin
        wordCnt_d = wordCnt_q + 1'b1;
        if (wordCnt_q == IDX_W'(WORDS_PER_COL - 1)) begin
          state_d   = ST_WAIT;
          wordCnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (pipeValid && pipeIdx == IDX_W'(WORDS_PER_COL - 1)) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (col_ready) begin
          if (colLastNow) begin
            state_d = ST_DONE;
          end else begin
            colCnt_d = colCnt_q + 1'b1;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Columns are contiguous in BRAM, so one running address covers the whole map.
    if (state_d == ST_ISSUE) begin
      issueAddr  = (state_q == ST_IDLE) ? BASE_ADDR : nextAddr_q;
      bramAddr_d = issueAddr;
      nextAddr_d = issueAddr + 1'b1;
    end
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      for (int p = 0; p < PIX_H; p++) dataCol_q[p] <= '0;
    end else if (pipeValid) begin
      for (int p = 0; p < PIX_H; p++) begin
        if (pipeIdx == IDX_W'(p / PIX_PER_WORD))
          dataCol_q[p] <= bram_rddata_b[(p % PIX_PER_WORD) * PIXEL_W +: PIXEL_W];
      end
    end
  end

  assign bram_en_b   = (state_q == ST_ISSUE);
  assign bram_addr_b = bramAddr_q;
  assign col_valid   = (state_q == ST_PRESENT);
  assign col_last    = (state_q == ST_PRESENT) && colLastNow;
  assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_PRESENT);
  assign done        = (state_q == ST_DONE);
  assign data_col    = dataCol_q;

endmodule
